// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate generator stage with 2-entry skid buffer; optional CSR uimm via IMM_CSR_EN
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    logic [31:0]      imm32;
    logic             ill_c;
    logic [XLEN-1:0]  imm_ext;
    logic             unused_inst_bits;

    assign unused_inst_bits = ^in_inst[6:0];

    always_comb begin
        imm32 = '0;
        ill_c = 1'b0;
        case (in_type)
            3'd0: imm32 = '0;
            3'd1: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            3'd2: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            3'd3: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                           in_inst[30:25], in_inst[11:8], 1'b0};
            3'd4: imm32 = {in_inst[31:12], 12'b0};
            3'd5: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0};
`ifdef IMM_CSR_EN
            // bit 31 is clear here, so the common sign-widening below zero-extends
            3'd6: imm32 = {27'b0, in_inst[19:15]};
`endif
            default: ill_c = 1'b1;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_wide
            assign imm_ext = {{32{imm32[31]}}, imm32};
        end else begin : g_narrow
            assign imm_ext = imm32;
        end
    endgenerate

    logic             main_valid_q, main_valid_d;
    logic [XLEN-1:0]  main_imm_q, main_imm_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic             main_ill_q, main_ill_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_ill_q, skid_ill_d;
    logic             in_ready_q, in_ready_d;
    logic             accept, xfer;

    assign accept = in_valid && in_ready_q;
    assign xfer   = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_tag_d   = main_tag_q;
        main_ill_d   = main_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_ill_d   = skid_ill_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || xfer) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_imm_d   = skid_imm_q;
                main_tag_d   = skid_tag_q;
                main_ill_d   = skid_ill_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_imm_d = imm_ext;
                    skid_tag_d = in_tag;
                    skid_ill_d = ill_c;
                end
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_imm_d   = imm_ext;
                main_tag_d   = in_tag;
                main_ill_d   = ill_c;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = imm_ext;
            skid_tag_d   = in_tag;
            skid_ill_d   = ill_c;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_tag_q   <= '0;
            main_ill_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_ill_q   <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_tag_q   <= main_tag_d;
            main_ill_q   <= main_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_ill_q   <= skid_ill_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign out_imm     = main_imm_q;
    assign out_tag     = main_tag_q;
    assign out_illegal = main_ill_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - directed self-checking bench for imm_gen_stage at XLEN 32 and 64
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [2:0]  in_type;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_illegal_a;
    logic [31:0] out_imm_a, out_tag_a;
    logic        in_ready_b, out_valid_b, out_illegal_b;
    logic [63:0] out_imm_b;
    logic [31:0] out_tag_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_imm(out_imm_a), .out_tag(out_tag_a), .out_illegal(out_illegal_a)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(32)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_imm(out_imm_b), .out_tag(out_tag_b), .out_illegal(out_illegal_b)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [2:0] t, input logic [31:0] tag);
        in_valid = v;
        in_inst  = inst;
        in_type  = t;
        in_tag   = tag;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [31:0] tag,
                              input logic [63:0] imm64, input logic ill);
        chk({name, ".valid32"}, {63'b0, out_valid_a}, {63'b0, v});
        chk({name, ".valid64"}, {63'b0, out_valid_b}, {63'b0, v});
        chk({name, ".tag32"}, {32'b0, out_tag_a}, {32'b0, tag});
        chk({name, ".tag64"}, {32'b0, out_tag_b}, {32'b0, tag});
        chk({name, ".imm32"}, {32'b0, out_imm_a}, {32'b0, imm64[31:0]});
        chk({name, ".imm64"}, out_imm_b, imm64);
        chk({name, ".ill32"}, {63'b0, out_illegal_a}, {63'b0, ill});
        chk({name, ".ill64"}, {63'b0, out_illegal_b}, {63'b0, ill});
    endtask

    logic [31:0] v_inst [9];
    logic [2:0]  v_type [9];
    logic [63:0] v_imm  [9];
    logic        v_ill  [9];

    initial begin
        v_inst[0] = 32'hFFF00093; v_type[0] = 3'd1; v_imm[0] = 64'hFFFFFFFF_FFFFFFFF; v_ill[0] = 1'b0;
        v_inst[1] = 32'h02A00093; v_type[1] = 3'd1; v_imm[1] = 64'h00000000_0000002A; v_ill[1] = 1'b0;
        v_inst[2] = 32'h00808463; v_type[2] = 3'd3; v_imm[2] = 64'h00000000_00000008; v_ill[2] = 1'b0;
        v_inst[3] = 32'hFE000EE3; v_type[3] = 3'd3; v_imm[3] = 64'hFFFFFFFF_FFFFFFFC; v_ill[3] = 1'b0;
        v_inst[4] = 32'h123450B7; v_type[4] = 3'd4; v_imm[4] = 64'h00000000_12345000; v_ill[4] = 1'b0;
        v_inst[5] = 32'h800000B7; v_type[5] = 3'd4; v_imm[5] = 64'hFFFFFFFF_80000000; v_ill[5] = 1'b0;
        v_inst[6] = 32'h800000B7; v_type[6] = 3'd0; v_imm[6] = 64'h0;                 v_ill[6] = 1'b0;
        v_inst[7] = 32'hFFFFFFFF; v_type[7] = 3'd7; v_imm[7] = 64'h0;                 v_ill[7] = 1'b1;
        v_inst[8] = 32'h3400D073; v_type[8] = 3'd6;
`ifdef IMM_CSR_EN
        v_imm[8] = 64'h1; v_ill[8] = 1'b0;
`else
        v_imm[8] = 64'h0; v_ill[8] = 1'b1;
`endif

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        tick(); tick();
        expect_out("reset", 1'b0, 32'h0, 64'h0, 1'b0);
        chk("reset.in_ready", {63'b0, in_ready_a & in_ready_b}, 64'h1);
        @(negedge clk); rst_n = 1'b1;

        // I-type, one cycle latency
        out_ready = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 32'hFFF00093, 3'd1, 32'h10);
        tick();
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        expect_out("itype", 1'b1, 32'h10, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        tick();
        expect_out("itype_hold", 1'b0, 32'h10, 64'hFFFFFFFF_FFFFFFFF, 1'b0);

        // S then J back-to-back, no bubble
        drive(1'b1, 32'hFE112E23, 3'd2, 32'h100);
        tick();
        expect_out("stype", 1'b1, 32'h100, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
        drive(1'b1, 32'hFFDFF06F, 3'd5, 32'h104);
        tick();
        expect_out("jtype", 1'b1, 32'h104, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        tick();
        chk("sj_drain", {63'b0, out_valid_a}, 64'h0);

        // streamed table of formats, including U widening, illegal and Z
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, v_inst[i], v_type[i], 32'h500 + i);
            tick();
            expect_out($sformatf("vec%0d", i), 1'b1, 32'h500 + i, v_imm[i], v_ill[i]);
        end
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        tick();
        expect_out("vec_hold", 1'b0, 32'h508, v_imm[8], v_ill[8]);

        // backpressure: two held, third stalls, then drains in order
        out_ready = 1'b0;
        drive(1'b1, 32'h02A00093, 3'd1, 32'h200);
        tick();
        drive(1'b1, 32'h00808463, 3'd3, 32'h201);
        tick();
        chk("bp.in_ready_lo", {63'b0, in_ready_a | in_ready_b}, 64'h0);
        drive(1'b1, 32'hFFFFFFFF, 3'd7, 32'h202);
        tick();
        expect_out("bp.stall1", 1'b1, 32'h200, 64'h2A, 1'b0);
        tick();
        expect_out("bp.stall2", 1'b1, 32'h200, 64'h2A, 1'b0);
        out_ready = 1'b1;
        tick();
        expect_out("bp.second", 1'b1, 32'h201, 64'h8, 1'b0);
        chk("bp.in_ready_hi", {63'b0, in_ready_a & in_ready_b}, 64'h1);
        tick();
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        expect_out("bp.third", 1'b1, 32'h202, 64'h0, 1'b1);
        tick();
        chk("bp.drained", {63'b0, out_valid_a | out_valid_b}, 64'h0);

        // flush with both registers full
        out_ready = 1'b0;
        drive(1'b1, 32'h02A00093, 3'd1, 32'h300);
        tick();
        drive(1'b1, 32'h02A00093, 3'd1, 32'h304);
        tick();
        drive(1'b1, 32'h02A00093, 3'd1, 32'h308);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        chk("flush_full.valid", {63'b0, out_valid_a | out_valid_b}, 64'h0);
        chk("flush_full.in_ready", {63'b0, in_ready_a & in_ready_b}, 64'h1);

        // flush discards a same-cycle accepted input
        drive(1'b1, 32'h02A00093, 3'd1, 32'h310);
        tick();
        drive(1'b1, 32'h02A00093, 3'd1, 32'h314);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        out_ready = 1'b1;
        chk("flush_acc.valid", {63'b0, out_valid_a | out_valid_b}, 64'h0);
        tick();
        chk("flush_acc.no_ghost", {63'b0, out_valid_a | out_valid_b}, 64'h0);
        drive(1'b1, 32'h123450B7, 3'd4, 32'h318);
        tick();
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        expect_out("post_flush", 1'b1, 32'h318, 64'h12345000, 1'b0);

        // asynchronous reset mid-operation
        out_ready = 1'b0;
        drive(1'b1, 32'h02A00093, 3'd1, 32'h400);
        tick();
        tick();
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.valid", {63'b0, out_valid_a | out_valid_b}, 64'h0);
        chk("async_rst.in_ready", {63'b0, in_ready_a & in_ready_b}, 64'h1);
        chk("async_rst.imm", out_imm_b, 64'h0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
